// File: rtl/line_feeder_pkg.sv
// line_feeder_pkg: shared definitions for the line feeder.
//   - default line geometry (shared with the processing stage and writer)
//   - per-bank state encoding of the ping-pong line buffers
//   - drain FSM state encoding
package line_feeder_pkg;

  localparam int unsigned DEF_WIDTH  = 1600;  // words per line
  localparam int unsigned DEF_HEIGHT = 1200;  // lines per frame
  localparam int unsigned DEF_ADDR_W = 12;    // line-buffer address / word-counter width

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_DRAIN = 2'd2
  } bank_state_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ANNOUNCE = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_GAP      = 2'd3
  } drain_state_t;

endpackage

// File: rtl/line_ram.sv
// line_ram: simple dual-port line-buffer RAM, 32-bit words.
// The bank select is the address MSB, so each bank spans 2**ADDR_W words.
// Ports:
//   clk, rst_n       clock, async active-low reset (read register only)
//   we, waddr, wdata write port
//   re, raddr        read request; rdata updates on the next edge when re=1
//   rdata            registered read data, holds when re=0
module line_ram #(
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  logic [31:0]     wdata,
  input  logic            re,
  input  logic [ADDR_W:0] raddr,
  output logic [31:0]     rdata
);

  logic [31:0] mem [2**(ADDR_W+1)];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_feeder.sv
// line_feeder: packs an upstream 32-bit stream into two ping-pong line
// buffers and serves each complete line to the processing stage.
// Ports:
//   CLK, RST_N       clock, async active-low reset
//   SRC_VALID/READY  upstream handshake, SRC_DATA word
//   READ_LINE_DONE   1-cycle pulse: a line is ready to drain
//   IN_DE, IN_DATA   consumer takes IN_DATA in every IN_DE cycle
//   FRAME_DONE       1-cycle pulse after the last line of a frame drains
//   UNDERRUN         sticky: IN_DE seen outside DRAIN
//   DBG_STATE        drain FSM state
// Handshake: a word transfers on every rising edge where SRC_VALID and
// SRC_READY are both high; SRC_READY does not depend on SRC_VALID.
module line_feeder
  import line_feeder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         SRC_VALID,
  input  logic [31:0]  SRC_DATA,
  output logic         SRC_READY,
  output logic         READ_LINE_DONE,
  input  logic         IN_DE,
  output logic [31:0]  IN_DATA,
  output logic         FRAME_DONE,
  output logic         UNDERRUN,
  output drain_state_t DBG_STATE
);

  localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(HEIGHT - 1);

  drain_state_t      state, state_nx;
  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              underrun_q;

  logic              fill_acc, fill_last, take, drain_last;
  logic              ram_re;
  logic [ADDR_W:0]   ram_raddr;

  assign SRC_READY  = (bank_q[wr_bank] == BANK_EMPTY);
  assign fill_acc   = SRC_VALID && SRC_READY;
  assign fill_last  = fill_acc && (wr_cnt == LAST_WORD);
  assign take       = (state == ST_DRAIN) && IN_DE;
  assign drain_last = take && (rd_cnt == LAST_WORD);

  // Fill and drain always touch different banks (fill only targets an
  // EMPTY bank), so both updates can land in the same cycle.
  always_comb begin
    state_nx  = state;
    bank_d    = bank_q;
    ram_re    = 1'b0;
    ram_raddr = {rd_bank, {ADDR_W{1'b0}}};
    case (state)
      ST_IDLE: begin
        if (bank_q[rd_bank] == BANK_FULL) state_nx = ST_ANNOUNCE;
      end
      ST_ANNOUNCE: begin
        ram_re          = 1'b1;
        bank_d[rd_bank] = BANK_DRAIN;
        state_nx        = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (IN_DE) begin
          if (rd_cnt == LAST_WORD) begin
            bank_d[rd_bank] = BANK_EMPTY;
            state_nx        = ST_GAP;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = {rd_bank, rd_cnt + ADDR_W'(1)};
          end
        end
      end
      ST_GAP: begin
        // rd_bank has already toggled; a waiting line is announced at once,
        // giving exactly two cycles from the last IN_DE to READ_LINE_DONE.
        if (bank_q[rd_bank] == BANK_FULL) state_nx = ST_ANNOUNCE;
        else                              state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (fill_last) bank_d[wr_bank] = BANK_FULL;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      bank_q[0]  <= BANK_EMPTY;
      bank_q[1]  <= BANK_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      line_cnt   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state     <= state_nx;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      if (fill_acc) begin
        if (fill_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + ADDR_W'(1);
        end
      end
      if (take) begin
        if (drain_last) begin
          rd_cnt   <= '0;
          rd_bank  <= ~rd_bank;
          line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + LINE_W'(1);
        end else begin
          rd_cnt   <= rd_cnt + ADDR_W'(1);
        end
      end
      if (IN_DE && (state != ST_DRAIN)) underrun_q <= 1'b1;
    end
  end

  line_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (fill_acc),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (SRC_DATA),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (IN_DATA)
  );

  assign READ_LINE_DONE = (state == ST_ANNOUNCE);
  // line_cnt steps on every entry to GAP, so zero here means it just wrapped.
  assign FRAME_DONE     = (state == ST_GAP) && (line_cnt == '0);
  assign UNDERRUN       = underrun_q;
  assign DBG_STATE      = state;

endmodule

// File: tb/tb_line_feeder.sv
// tb_line_feeder: randomized bench for line_feeder (WIDTH=8, HEIGHT=2).
// The reference model works on whole words and lines: a queue of accepted
// words, the cycle each line completed, and the cycle each line finished
// draining. Announce time of a line = max(line complete, previous drained)+2.
module tb_line_feeder;

  localparam int W = 8;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        in_de = 1'b0;
  logic        src_ready, rld, frame_done, underrun;
  logic [31:0] in_data;
  logic [1:0]  dbg_state;

  line_feeder #(.WIDTH(W), .HEIGHT(H), .ADDR_W(4)) dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .SRC_VALID      (src_valid),
    .SRC_DATA       (src_data),
    .SRC_READY      (src_ready),
    .READ_LINE_DONE (rld),
    .IN_DE          (in_de),
    .IN_DATA        (in_data),
    .FRAME_DONE     (frame_done),
    .UNDERRUN       (underrun),
    .DBG_STATE      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  logic [31:0] exp_q [$];
  int          fill_t [$];
  int          acc, nann, ndrn, rd_pos, last_d, fd_exp, drain_start;
  bit          exp_under;

  // ---------------- stimulus controls ----------------
  bit src_on, rand_valid, cons_on, gap_mode, force_de;
  int src_limit, gap_ph;

  task automatic model_clear();
    exp_q.delete();
    fill_t.delete();
    acc = 0; nann = 0; ndrn = 0; rd_pos = 0;
    last_d = -100; fd_exp = -1; drain_start = 0;
    exp_under = 0; gap_ph = 0;
    src_on = 0; rand_valid = 0; cons_on = 0; gap_mode = 0; force_de = 0;
    src_limit = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, drive inputs,
  // advance the model to what the next rising edge commits.
  task automatic tick();
    bit draining, exp_ready, exp_rld, de, vld;
    int ann_t;
    @(negedge clk);
    draining  = (nann > ndrn) && (cyc >= drain_start);
    exp_ready = ((acc / W) - ndrn) < 2;
    exp_rld   = 0;
    if (nann == ndrn && nann < fill_t.size()) begin
      ann_t   = ((fill_t[nann] > last_d) ? fill_t[nann] : last_d) + 2;
      exp_rld = (cyc == ann_t);
    end

    checks++;
    if (src_ready !== exp_ready) begin
      errors++;
      $display("FAIL src_ready cyc=%0d got=%b exp=%b", cyc, src_ready, exp_ready);
    end
    checks++;
    if (rld !== exp_rld) begin
      errors++;
      $display("FAIL read_line_done cyc=%0d got=%b exp=%b", cyc, rld, exp_rld);
    end
    checks++;
    if (frame_done !== (cyc == fd_exp)) begin
      errors++;
      $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, (cyc == fd_exp));
    end
    checks++;
    if (underrun !== exp_under) begin
      errors++;
      $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, exp_under);
    end
    if (draining) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL in_data cyc=%0d got=%h exp=<none>", cyc, in_data);
      end else if (in_data !== exp_q[0]) begin
        errors++;
        $display("FAIL in_data cyc=%0d got=%h exp=%h", cyc, in_data, exp_q[0]);
      end
    end

    de  = force_de || (cons_on && draining && (!gap_mode || gap_ph == 0));
    vld = src_on && (acc < src_limit) && (!rand_valid || $urandom_range(0, 3) != 0);
    src_valid = vld;
    src_data  = $urandom;
    in_de     = de;

    if (exp_rld) begin
      nann++;
      drain_start = cyc + 1;
      gap_ph = 0;
    end
    if (de && !draining) exp_under = 1;
    if (draining && gap_mode) gap_ph = (gap_ph + 1) % 3;
    if (de && draining) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      rd_pos++;
      if (rd_pos == W) begin
        rd_pos = 0;
        if (ndrn % H == H - 1) fd_exp = cyc + 1;
        ndrn++;
        last_d = cyc;
      end
    end
    if (vld && exp_ready) begin
      exp_q.push_back(src_data);
      acc++;
      if (acc % W == 0) fill_t.push_back(cyc);
    end

    @(posedge clk);
    cyc++;
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    src_valid = 1'b0;
    in_de = 1'b0;
    #1;
    checks++;
    if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready got=%b exp=1", src_ready); end
    checks++;
    if (rld !== 1'b0) begin errors++; $display("FAIL reset_read_line_done got=%b exp=0", rld); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++;
    if (in_data !== 32'h0) begin errors++; $display("FAIL reset_in_data got=%h exp=0", in_data); end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    run(4);
  endtask

  task automatic test_single_line();
    do_reset();
    src_on = 1; src_limit = W; cons_on = 1;
    run(30);
  endtask

  task automatic test_backpressure();
    do_reset();
    src_on = 1; src_limit = 4 * W;
    run(30);
    cons_on = 1;
    run(80);
  endtask

  task automatic test_back_to_back();
    do_reset();
    src_on = 1; src_limit = 6 * W; rand_valid = 1; cons_on = 1;
    run(150);
  endtask

  task automatic test_underrun();
    do_reset();
    force_de = 1;
    run(2);
    force_de = 0;
    src_on = 1; src_limit = W; cons_on = 1;
    run(30);
  endtask

  task automatic test_gapped();
    do_reset();
    src_on = 1; src_limit = 2 * W; cons_on = 1; gap_mode = 1;
    run(90);
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_on = 1; src_limit = 5;
    run(8);
    do_reset();
    src_on = 1; src_limit = W; cons_on = 1;
    run(W + 7);
    do_reset();
    src_on = 1; src_limit = W; cons_on = 1;
    run(30);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_single_line();
    test_backpressure();
    test_back_to_back();
    test_underrun();
    test_gapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
